pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
Control-side counterpart of the 5-stage datapath. It decodes the ID-stage instruction (IF_ID_instruction) and the C/Z flags returned by the datapath, then drives every datapath control input. It stages the per-instruction controls through ID/EX, EX/MEM and MEM/WB registers. It detects flag and load-use hazards and issues stall and flush.

Parameters:
INST_W, 19, instruction width
CNT_W, 16, width of performance counters (used only under PERF_COUNT_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low
IF_ID_instruction  input  19  instruction currently in ID
C  input  1  carry flag from datapath
Z  input  1  zero flag from datapath
pc_mux  output  2  00 pc+1, 01 pc+offset, 10 absolute, 11 stack_out (ID stage)
push  output  1  JSR return-address push (ID stage)
pop  output  1  RET pop (ID stage)
reg_B_mux  output  1  1 selects [13:11] as read address B, used by SW (ID stage)
alu_op  output  3  EX stage
alu_in_mux  output  1  1 selects immediate (EX stage)
alu_use_carry  output  1  EX stage
select_c  output  1  EX stage, 1 selects shifter flag
select_z  output  1  EX stage, 1 selects shifter flag
write_c  output  1  EX stage
write_z  output  1  EX stage
mem_write  output  1  MEM stage
reg_write  output  1  WB stage
reg_write_mux  output  2  00 alu, 01 shifter, 10 memory (WB stage)
stall  output  1  hold PC and IF_ID, inject bubble into EX
flush  output  1  clear IF_ID next edge

Behaviour:
- Reset: sampled on rising edge of clk while reset==0. All pipeline control registers clear to the bubble encoding (all zero). All outputs are 0 in the following cycle. Reset applied mid-operation discards every in-flight instruction.
- Decode uses fields of IF_ID_instruction:
  - [18:17]=00: R-ALU. alu_op=[16:14]. Sources A=[10:8], B=[7:5]. reg_write=1, write_c=1, write_z=1.
  - [18:17]=01: I-ALU. Same as R-ALU, plus alu_in_mux=1.
  - [18:16]=110: shift. reg_write_mux=01, select_c=1, select_z=1, write_c=1, write_z=1.
  - [18:16]=100: memory. [15:14]=00 is LW (reg_write=1, reg_write_mux=10). 01 is SW (mem_write=1, reg_B_mux=1). 1x is NOP.
  - [18:16]=101: branch. [15:14] selects condition: 00 Z, 01 !Z, 10 C, 11 !C. If taken, pc_mux=01.
  - [18:16]=111: [15:14]=00 JMP (pc_mux=10). 01 JSR (pc_mux=10, push=1). 10 RET (pc_mux=11, pop=1). 11 NOP.
- alu_use_carry=1 when alu_op is 001 (addc) or 011 (subc) on ALU-class instructions.
- Latency from ID: EX controls appear 1 cycle after ID, mem_write after 2 cycles, reg_write and reg_write_mux after 3 cycles.
- Flag hazard: a branch in ID while write_c/write_z of the EX stage covers its tested flag sets stall=1 for 1 cycle. While stalled, pc_mux=00, push=pop=0, flush=0, and a bubble enters ID/EX.
- Load-use hazard: LW in EX whose dest [13:11] equals a source register read by the ID instruction sets stall=1 for 1 cycle.
- Control transfer: any taken branch, JMP, JSR or RET sets flush=1 in the same cycle as its pc_mux.
- Priority: stall dominates control transfer. stall and flush are never both 1.
- Back-to-back control transfers: the second is flushed, so it never issues.
- A bubble never asserts any write enable.

Optional Feature:
PERF_COUNT_EN: when defined, adds outputs stall_count and flush_count, each CNT_W bits. Each increments on every cycle its signal is 1, saturates at all-ones, and clears on reset. When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles while IF_ID_instruction is R-ALU -> all outputs 0; first R-ALU gives write_c=write_z=1 one cycle after release and reg_write=1 three cycles after.
- I-ALU: opcode 01, alu_op=001, C=1 -> the next cycle shows alu_in_mux=1 and alu_use_carry=1.
- Taken branch: BZ with Z=1, no flag writer in EX -> pc_mux=01, flush=1 for one cycle; with Z=0 -> pc_mux=00, flush=0.
- Flag hazard: R-ALU followed by BNZ -> stall=1 for exactly 1 cycle, then the branch resolves on the updated Z.
- Load-use: LW r3 then R-ALU reading r3 -> stall=1 for one cycle, and the bubble produces no reg_write three cycles later.
- Call/return: JSR then RET (with NOPs between) -> push=1 with pc_mux=10, later pop=1 with pc_mux=11, and flush=1 on both.

Source files
------------

// File: rtl/pipeline_controller.sv
// pipeline_controller: ID decode, EX/MEM/WB control staging, stall and flush.
// Define PERF_COUNT_EN to add saturating stall_count / flush_count outputs.
module pipeline_controller #(
    parameter int INST_W = 19,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] IF_ID_instruction,
    input  logic              C,
    input  logic              Z,
    output logic [1:0]        pc_mux,
    output logic              push,
    output logic              pop,
    output logic              reg_B_mux,
    output logic [2:0]        alu_op,
    output logic              alu_in_mux,
    output logic              alu_use_carry,
    output logic              select_c,
    output logic              select_z,
    output logic              write_c,
    output logic              write_z,
    output logic              mem_write,
    output logic              reg_write,
    output logic [1:0]        reg_write_mux,
    output logic              stall,
    output logic              flush
`ifdef PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    logic [18:0] w_ins;
    logic [1:0]  w_sub;
    logic        w_id_ok;
    logic        w_taken;

    logic [2:0]  w_alu_op;
    logic        w_in_mux, w_carry, w_sel_c, w_sel_z;
    logic        w_wc, w_wz, w_mw, w_rw, w_lw;
    logic [1:0]  w_rwm;
    logic [1:0]  w_pc;
    logic        w_push, w_pop, w_rbm, w_br;
    logic        w_rd_a, w_rd_b, w_rd_s;
    logic        w_lu, w_fh, w_stall;

    logic [2:0]  r_ex_alu_op;
    logic        r_ex_in_mux, r_ex_carry, r_ex_sel_c, r_ex_sel_z;
    logic        r_ex_wc, r_ex_wz, r_ex_mw, r_ex_rw, r_ex_lw;
    logic [1:0]  r_ex_rwm;
    logic [2:0]  r_ex_rd;
    logic        r_mem_mw, r_mem_rw;
    logic [1:0]  r_mem_rwm;
    logic        r_wb_rw;
    logic [1:0]  r_wb_rwm;
    logic        r_kill;

    assign w_ins   = IF_ID_instruction[18:0];
    assign w_sub   = w_ins[15:14];
    // The slot right after a flush holds a squashed fetch; it never issues.
    assign w_id_ok = reset & ~r_kill;
    assign w_taken = (w_sub[1] ? C : Z) ^ w_sub[0];

    // Decode the ID instruction; a register source is flagged only if read.
    always_comb begin
        w_alu_op = 3'b000;
        w_in_mux = 1'b0;
        w_carry  = 1'b0;
        w_sel_c  = 1'b0;
        w_sel_z  = 1'b0;
        w_wc     = 1'b0;
        w_wz     = 1'b0;
        w_mw     = 1'b0;
        w_rw     = 1'b0;
        w_rwm    = 2'b00;
        w_lw     = 1'b0;
        w_pc     = 2'b00;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_rbm    = 1'b0;
        w_br     = 1'b0;
        w_rd_a   = 1'b0;
        w_rd_b   = 1'b0;
        w_rd_s   = 1'b0;
        if (w_id_ok) begin
            unique case (1'b1)
                !w_ins[18]: begin
                    w_alu_op = w_ins[16:14];
                    w_in_mux = w_ins[17];
                    w_carry  = (w_ins[16:14] == 3'b001) ||
                               (w_ins[16:14] == 3'b011);
                    w_wc     = 1'b1;
                    w_wz     = 1'b1;
                    w_rw     = 1'b1;
                    w_rd_a   = 1'b1;
                    w_rd_b   = ~w_ins[17];
                end
                (w_ins[18:16] == 3'b110): begin
                    w_sel_c = 1'b1;
                    w_sel_z = 1'b1;
                    w_wc    = 1'b1;
                    w_wz    = 1'b1;
                    w_rw    = 1'b1;
                    w_rwm   = 2'b01;
                    w_rd_a  = 1'b1;
                end
                (w_ins[18:16] == 3'b100): begin
                    case (w_sub)
                        2'b00: begin
                            w_rw   = 1'b1;
                            w_rwm  = 2'b10;
                            w_lw   = 1'b1;
                            w_rd_a = 1'b1;
                        end
                        2'b01: begin
                            w_mw   = 1'b1;
                            w_rbm  = 1'b1;
                            w_rd_a = 1'b1;
                            w_rd_s = 1'b1;
                        end
                        default: ;
                    endcase
                end
                (w_ins[18:16] == 3'b101): begin
                    w_br = 1'b1;
                    w_pc = w_taken ? 2'b01 : 2'b00;
                end
                (w_ins[18:16] == 3'b111): begin
                    case (w_sub)
                        2'b00: w_pc = 2'b10;
                        2'b01: begin
                            w_pc   = 2'b10;
                            w_push = 1'b1;
                        end
                        2'b10: begin
                            w_pc  = 2'b11;
                            w_pop = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign w_lu = r_ex_lw & (
        (w_rd_a & (w_ins[10:8]  == r_ex_rd)) |
        (w_rd_b & (w_ins[7:5]   == r_ex_rd)) |
        (w_rd_s & (w_ins[13:11] == r_ex_rd)));
    assign w_fh    = w_br & (w_sub[1] ? r_ex_wc : r_ex_wz);
    assign w_stall = w_lu | w_fh;

    assign stall         = w_stall;
    assign flush         = ~w_stall & (w_pc != 2'b00);
    assign pc_mux        = w_stall ? 2'b00 : w_pc;
    assign push          = w_push & ~w_stall;
    assign pop           = w_pop & ~w_stall;
    assign reg_B_mux     = w_rbm;
    assign alu_op        = r_ex_alu_op;
    assign alu_in_mux    = r_ex_in_mux;
    assign alu_use_carry = r_ex_carry;
    assign select_c      = r_ex_sel_c;
    assign select_z      = r_ex_sel_z;
    assign write_c       = r_ex_wc;
    assign write_z       = r_ex_wz;
    assign mem_write     = r_mem_mw;
    assign reg_write     = r_wb_rw;
    assign reg_write_mux = r_wb_rwm;

    // Advance controls ID->EX->MEM->WB; a stall drops a bubble into EX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex_alu_op <= 3'b000;
            r_ex_in_mux <= 1'b0;
            r_ex_carry  <= 1'b0;
            r_ex_sel_c  <= 1'b0;
            r_ex_sel_z  <= 1'b0;
            r_ex_wc     <= 1'b0;
            r_ex_wz     <= 1'b0;
            r_ex_mw     <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_rwm    <= 2'b00;
            r_ex_lw     <= 1'b0;
            r_ex_rd     <= 3'b000;
            r_mem_mw    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_rwm   <= 2'b00;
            r_wb_rw     <= 1'b0;
            r_wb_rwm    <= 2'b00;
            r_kill      <= 1'b0;
        end else begin
            if (w_stall) begin
                r_ex_alu_op <= 3'b000;
                r_ex_in_mux <= 1'b0;
                r_ex_carry  <= 1'b0;
                r_ex_sel_c  <= 1'b0;
                r_ex_sel_z  <= 1'b0;
                r_ex_wc     <= 1'b0;
                r_ex_wz     <= 1'b0;
                r_ex_mw     <= 1'b0;
                r_ex_rw     <= 1'b0;
                r_ex_rwm    <= 2'b00;
                r_ex_lw     <= 1'b0;
                r_ex_rd     <= 3'b000;
            end else begin
                r_ex_alu_op <= w_alu_op;
                r_ex_in_mux <= w_in_mux;
                r_ex_carry  <= w_carry;
                r_ex_sel_c  <= w_sel_c;
                r_ex_sel_z  <= w_sel_z;
                r_ex_wc     <= w_wc;
                r_ex_wz     <= w_wz;
                r_ex_mw     <= w_mw;
                r_ex_rw     <= w_rw;
                r_ex_rwm    <= w_rwm;
                r_ex_lw     <= w_lw;
                r_ex_rd     <= w_lw ? w_ins[13:11] : 3'b000;
            end
            r_mem_mw  <= r_ex_mw;
            r_mem_rw  <= r_ex_rw;
            r_mem_rwm <= r_ex_rwm;
            r_wb_rw   <= r_mem_rw;
            r_wb_rwm  <= r_mem_rwm;
            r_kill    <= flush;
        end
    end

`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counts of stall and flush cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + ONE;
            if (flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + ONE;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed + random stimulus against a
// queue-based model of instruction issue, hazards and stage latency.
module tb_pipeline_controller;

    localparam int INST_W = 19;
    localparam int CNT_W  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] instr;
    logic        C, Z;
    logic [1:0]  pc_mux;
    logic        push, pop, reg_B_mux;
    logic [2:0]  alu_op;
    logic        alu_in_mux, alu_use_carry, select_c, select_z;
    logic        write_c, write_z, mem_write, reg_write;
    logic [1:0]  reg_write_mux;
    logic        stall, flush;
`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [CNT_W-1:0] m_sc = '0, m_fc = '0;
`endif

    always #5 clk = ~clk;

    pipeline_controller #(.INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .IF_ID_instruction(instr),
        .C(C), .Z(Z), .pc_mux(pc_mux), .push(push), .pop(pop),
        .reg_B_mux(reg_B_mux), .alu_op(alu_op),
        .alu_in_mux(alu_in_mux), .alu_use_carry(alu_use_carry),
        .select_c(select_c), .select_z(select_z),
        .write_c(write_c), .write_z(write_z),
        .mem_write(mem_write), .reg_write(reg_write),
        .reg_write_mux(reg_write_mux), .stall(stall), .flush(flush)
`ifdef PERF_COUNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    typedef struct packed {
        logic [2:0] alu_op;
        logic       in_mux, carry, sel_c, sel_z, wc, wz, mw, rw;
        logic [1:0] rwm;
        logic       is_lw;
        logic [2:0] rd;
    } rec_t;

    rec_t        q[$];
    bit          model_ok = 0;
    bit          kill = 0;
    int          checks = 0;
    int          errors = 0;
    logic        exp_stall = 1'b0;
    logic        exp_flush = 1'b0;

    localparam logic [18:0] NOP = {3'b100, 2'b10, 14'd0};

    function automatic logic [18:0] ralu(input logic [2:0] op,
        input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b);
        return {2'b00, op, rd, a, b, 5'd0};
    endfunction

    function automatic logic [18:0] ctl(input logic [2:0] top,
        input logic [1:0] sub);
        return {top, sub, 14'd0};
    endfunction

    function automatic logic [19:0] act_vec();
        return {pc_mux, push, pop, reg_B_mux, alu_op, alu_in_mux,
                alu_use_carry, select_c, select_z, write_c, write_z,
                mem_write, reg_write, reg_write_mux, stall, flush};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Spec-level model: what the ID instruction issues, and its hazards.
    task automatic model_step();
        rec_t       r, ex, mem, wb;
        logic [1:0] pcm, sub;
        logic [2:0] top3;
        logic       psh, pp, rbm, br, taken, lu, fh;
        bit [7:0]   rmask;
        logic [19:0] exp_v;
        r = '0; pcm = 2'b00; psh = 0; pp = 0; rbm = 0;
        br = 0; lu = 0; fh = 0; rmask = '0; taken = 0;
        ex = q[0]; mem = q[1]; wb = q[2];
        top3 = instr[18:16];
        sub  = instr[15:14];
        if (reset && !kill) begin
            if (instr[18] == 1'b0) begin
                r.alu_op = instr[16:14];
                r.in_mux = instr[17];
                r.carry  = (r.alu_op == 3'd1) || (r.alu_op == 3'd3);
                r.wc = 1; r.wz = 1; r.rw = 1;
                rmask[instr[10:8]] = 1'b1;
                if (!instr[17]) rmask[instr[7:5]] = 1'b1;
            end else if (top3 == 3'b110) begin
                r.sel_c = 1; r.sel_z = 1; r.wc = 1; r.wz = 1;
                r.rw = 1; r.rwm = 2'b01;
                rmask[instr[10:8]] = 1'b1;
            end else if (top3 == 3'b100) begin
                if (sub == 2'b00) begin
                    r.rw = 1; r.rwm = 2'b10; r.is_lw = 1;
                    r.rd = instr[13:11];
                    rmask[instr[10:8]] = 1'b1;
                end else if (sub == 2'b01) begin
                    r.mw = 1; rbm = 1;
                    rmask[instr[10:8]]  = 1'b1;
                    rmask[instr[13:11]] = 1'b1;
                end
            end else if (top3 == 3'b101) begin
                br = 1;
                case (sub)
                    2'b00: taken = Z;
                    2'b01: taken = !Z;
                    2'b10: taken = C;
                    default: taken = !C;
                endcase
                if (taken) pcm = 2'b01;
            end else begin
                if (sub == 2'b00) pcm = 2'b10;
                if (sub == 2'b01) begin pcm = 2'b10; psh = 1; end
                if (sub == 2'b10) begin pcm = 2'b11; pp = 1; end
            end
            lu = ex.is_lw && rmask[ex.rd];
            fh = br && (sub[1] ? ex.wc : ex.wz);
        end
        exp_stall = lu || fh;
        if (exp_stall) begin
            pcm = 2'b00; psh = 0; pp = 0; r = '0;
        end
        exp_flush = (pcm != 2'b00);
        exp_v = {pcm, psh, pp, rbm, ex.alu_op, ex.in_mux, ex.carry,
                 ex.sel_c, ex.sel_z, ex.wc, ex.wz, mem.mw, wb.rw,
                 wb.rwm, exp_stall, exp_flush};
        if (model_ok) begin
            check("cycle_outputs", {12'd0, act_vec()}, {12'd0, exp_v});
`ifdef PERF_COUNT_EN
            check("stall_count", {16'd0, stall_count}, {16'd0, m_sc});
            check("flush_count", {16'd0, flush_count}, {16'd0, m_fc});
`endif
        end
        if (!reset) begin
            q.delete();
            repeat (3) q.push_back('0);
            kill = 0;
            model_ok = 1;
`ifdef PERF_COUNT_EN
            m_sc = '0; m_fc = '0;
`endif
        end else begin
            void'(q.pop_back());
            q.push_front(r);
            kill = exp_flush;
`ifdef PERF_COUNT_EN
            if (exp_stall && m_sc != '1) m_sc = m_sc + 1'b1;
            if (exp_flush && m_fc != '1) m_fc = m_fc + 1'b1;
`endif
        end
    endtask

    task automatic step(input logic [18:0] ins, input logic c,
        input logic z, input logic rs);
        @(posedge clk);
        #1;
        instr = ins; C = c; Z = z; reset = rs;
        @(negedge clk);
        model_step();
    endtask

    function automatic logic [18:0] rnd_ins();
        logic [18:0] x;
        x = 19'($urandom);
        x[13:11] = 3'($urandom_range(0, 3));
        x[10:8]  = 3'($urandom_range(0, 3));
        x[7:5]   = 3'($urandom_range(0, 3));
        return x;
    endfunction

    initial begin
        logic [18:0] cur;
        logic [18:0] ra;
        logic [18:0] rd3;
        repeat (3) q.push_back('0);
        reset = 1'b0;
        ra = ralu(3'd0, 3'd1, 3'd2, 3'd3);
        instr = ra; C = 0; Z = 0;

        step(ra, 0, 0, 0);
        step(ra, 0, 0, 0);
        check("reset_outputs", {12'd0, act_vec()}, 32'd0);
        step(ra, 0, 0, 1);
        step(ra, 0, 0, 1);
        check("rst_write_c", {31'd0, write_c}, 32'd1);
        check("rst_write_z", {31'd0, write_z}, 32'd1);
        step(ra, 0, 0, 1);
        step(ra, 0, 0, 1);
        check("rst_reg_write", {31'd0, reg_write}, 32'd1);

        step({2'b01, 3'b001, 3'd4, 3'd5, 8'd9}, 1, 0, 1);
        step(NOP, 1, 0, 1);
        check("ialu_in_mux", {31'd0, alu_in_mux}, 32'd1);
        check("ialu_carry", {31'd0, alu_use_carry}, 32'd1);

        step(NOP, 0, 0, 1);
        step(ctl(3'b101, 2'b00), 0, 1, 1);
        check("bz_taken_pc", {30'd0, pc_mux}, 32'd1);
        check("bz_taken_flush", {31'd0, flush}, 32'd1);
        step(NOP, 0, 0, 1);
        step(ctl(3'b101, 2'b00), 0, 0, 1);
        check("bz_not_pc", {30'd0, pc_mux}, 32'd0);
        check("bz_not_flush", {31'd0, flush}, 32'd0);

        step(ra, 0, 0, 1);
        step(ctl(3'b101, 2'b01), 0, 1, 1);
        check("flag_stall", {31'd0, stall}, 32'd1);
        check("flag_stall_pc", {30'd0, pc_mux}, 32'd0);
        step(ctl(3'b101, 2'b01), 0, 0, 1);
        check("flag_release", {31'd0, stall}, 32'd0);
        check("flag_bnz_pc", {30'd0, pc_mux}, 32'd1);
        check("flag_bnz_flush", {31'd0, flush}, 32'd1);
        step(NOP, 0, 0, 1);

        rd3 = ralu(3'd0, 3'd1, 3'd3, 3'd2);
        step({3'b100, 2'b00, 3'd3, 3'd0, 8'd0}, 0, 0, 1);
        step(rd3, 0, 0, 1);
        check("lu_stall", {31'd0, stall}, 32'd1);
        step(rd3, 0, 0, 1);
        check("lu_release", {31'd0, stall}, 32'd0);
        step(NOP, 0, 0, 1);
        check("lu_lw_wb", {29'd0, reg_write, reg_write_mux}, 32'h6);
        step(NOP, 0, 0, 1);
        check("lu_bubble_wb", {31'd0, reg_write}, 32'd0);
        step(NOP, 0, 0, 1);
        check("lu_alu_wb", {29'd0, reg_write, reg_write_mux}, 32'h4);

        step(ctl(3'b111, 2'b01), 0, 0, 1);
        check("jsr", {28'd0, pc_mux, push, flush}, 32'hB);
        step(NOP, 0, 0, 1);
        step(NOP, 0, 0, 1);
        step(ctl(3'b111, 2'b10), 0, 0, 1);
        check("ret", {28'd0, pc_mux, pop, flush}, 32'hF);

        step(NOP, 0, 0, 1);
        step(ctl(3'b111, 2'b00), 0, 0, 1);
        check("jmp_first", {29'd0, pc_mux, flush}, 32'h5);
        step(ctl(3'b111, 2'b00), 0, 0, 1);
        check("jmp_second", {29'd0, pc_mux, flush}, 32'h0);

        cur = NOP;
        repeat (2000) begin
            if (!exp_stall) cur = rnd_ins();
            step(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
